tdm_demux_8: RTL and testbench
==============================

TDM_DEMUX_8 -- requirements
Module: tdm_demux_8

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of input word and each output lane.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  input word present this cycle.
REQ-005 SHALL have port: in_sof  input  1  start of frame; meaningful only when in_valid=1.
REQ-006 SHALL have port: in_data  input  WIDTH  input word.
REQ-007 SHALL have ports: out0..out7  output  WIDTH each  registered lane outputs, lane n = slot n.
REQ-008 SHALL have port: out_strobe  output  8  one-hot, bit n pulses one cycle when outn updates.
REQ-009 SHALL have port: out_sel  output  3  slot index of most recent lane write.
REQ-010 SHALL have port: frame_valid  output  1  one-cycle pulse when slot 7 written (complete frame).
REQ-011 SHALL have port: frame_err  output  1  one-cycle pulse on sof received mid-frame.
REQ-012 SHALL have port: drop_cnt  output  8  count of words discarded in IDLE, saturating at 255.

Function
REQ-013 SHALL implement two states: IDLE (awaiting sof), RUN (collecting slots); 3-bit slot counter.
REQ-014 IDLE, in_valid=1 & in_sof=1: SHALL write in_data to out0, strobe bit0, out_sel=0, slot->1, go RUN.
REQ-015 IDLE, in_valid=1 & in_sof=0: SHALL discard word, no strobe, drop_cnt+1 unless already 255.
REQ-016 RUN, in_valid=1 & in_sof=0: SHALL write in_data to lane[slot], strobe bit[slot], out_sel=slot, slot+1.
REQ-017 RUN, slot=7 write: SHALL pulse frame_valid in the same cycle as strobe bit7, slot->0, go IDLE.
REQ-018 RUN, in_valid=1 & in_sof=1: SHALL pulse frame_err, write word to out0 as new frame, strobe bit0, slot->1, stay RUN; frame_valid not pulsed.
REQ-019 in_valid=0: SHALL hold state, slot, lanes; strobes, frame_valid, frame_err low; no timeout.
REQ-020 Latency: input sampled at edge k SHALL appear on lane, strobe, out_sel, frame_valid, frame_err after edge k (one cycle).
REQ-021 Lanes SHALL hold last written value indefinitely; unwritten lanes keep previous-frame data.
REQ-022 out_strobe SHALL be zero or exactly one-hot every cycle; frame_valid and frame_err never both high.
REQ-023 Slot counter SHALL wrap 7->0 only via REQ-017; no other wrap path.

Reset
REQ-024 rst=1 at an edge SHALL force: state IDLE, slot=0, out0..out7=0, out_strobe=0, out_sel=0, frame_valid=0, frame_err=0, drop_cnt=0.
REQ-025 rst SHALL override in_valid in the same cycle; word presented during reset is discarded and not counted.
REQ-026 Reset mid-frame SHALL abandon the partial frame with no frame_valid or frame_err pulse.

Verification
REQ-027 Full frame: after reset, 8 consecutive valid words 0x80,0x40,...,0x01, sof on first -> out0=0x80..out7=0x01, strobes 0x01..0x80 in order, frame_valid pulses once with strobe 0x80.
REQ-028 Gapped frame: same frame with in_valid=0 for 3 cycles between slots 3 and 4 -> identical lane contents, frame_valid only after 8th word, no strobes during gap.
REQ-029 Mid-frame sof: sof+0xAA, 0xBB, 0xCC, then sof+0x11 -> frame_err pulse on 4th word, out0=0x11, out1=0xBB retained, next word lands in out1.
REQ-030 Idle drop: 300 valid words without sof from IDLE -> drop_cnt=255 (saturated), no strobes, lanes unchanged.
REQ-031 Reset mid-frame: sof+0x01, 0x02, 0x03, rst high one cycle with in_valid=1 -> all lanes 0, drop_cnt 0, no pulses, next non-sof word dropped (drop_cnt=1).
REQ-032 Back-to-back frames: sof on cycle immediately after frame_valid -> second frame accepted with no frame_err, two frame_valid pulses 8 cycles apart.

Source files
------------

// File: rtl/tdm_demux_8.sv
// tdm_demux_8 -- eight-slot time-division demultiplexer.
//
// A frame is eight consecutive valid words; the word carrying in_sof is
// slot 0. Each word is written into the lane register matching its slot
// and the lane's strobe bit pulses for one cycle. Words arriving outside
// a frame are dropped and counted.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     input word present this cycle
//   in_sof       start of frame (qualified by in_valid)
//   in_data      input word
//   out0..out7   registered lane outputs, lane n = slot n
//   out_strobe   one-hot, bit n pulses when outn is written
//   out_sel      slot index of the most recent lane write
//   frame_valid  pulse when slot 7 completes a frame
//   frame_err    pulse when sof arrives mid-frame
//   drop_cnt     words discarded while idle, saturating at 255
module tdm_demux_8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [WIDTH-1:0] out6,
   output logic [WIDTH-1:0] out7,
   output logic [7:0]       out_strobe,
   output logic [2:0]       out_sel,
   output logic             frame_valid,
   output logic             frame_err,
   output logic [7:0]       drop_cnt
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       slot_q, slot_d;
   logic [7:0]       drop_q, drop_d;
   logic [WIDTH-1:0] lane_q [8];
   logic [7:0]       strobe_q;
   logic [2:0]       sel_q;
   logic             fv_q, fv_d;
   logic             fe_q, fe_d;
   logic             wr_en;
   logic [2:0]       wr_slot;

   // Next-state decode for the frame tracker.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      slot_d  = slot_q;
      drop_d  = drop_q;
      fv_d    = 1'b0;
      fe_d    = 1'b0;
      wr_en   = 1'b0;
      wr_slot = slot_q;

      if (in_valid) begin
         if (in_sof) begin
            // sof always restarts at slot 0; inside a frame it also flags
            // the abandoned partial frame.
            wr_en   = 1'b1;
            wr_slot = 3'd0;
            slot_d  = 3'd1;
            state_d = RUN;
            fe_d    = (state_q == RUN);
         end else if (state_q == IDLE) begin
            drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
         end else begin
            wr_en   = 1'b1;
            wr_slot = slot_q;
            // Slot 7 is the only place the counter wraps back to 0.
            slot_d  = slot_q + 3'd1;
            if (slot_q == 3'd7) begin
               fv_d    = 1'b1;
               state_d = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples values from before this edge.
      if (rst) begin
         state_q  <= IDLE;
         slot_q   <= 3'd0;
         drop_q   <= 8'd0;
         strobe_q <= 8'd0;
         sel_q    <= 3'd0;
         fv_q     <= 1'b0;
         fe_q     <= 1'b0;
         // NOTE: the lane array is cleared on reset because reset must
         // present all-zero lanes; it is small enough to be plain flops.
         for (int i = 0; i < 8; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         drop_q   <= drop_d;
         fv_q     <= fv_d;
         fe_q     <= fe_d;
         strobe_q <= wr_en ? (8'd1 << wr_slot) : 8'd0;
         if (wr_en) begin
            lane_q[wr_slot] <= in_data;
            sel_q           <= wr_slot;
         end
      end
   end

   assign out0        = lane_q[0];
   assign out1        = lane_q[1];
   assign out2        = lane_q[2];
   assign out3        = lane_q[3];
   assign out4        = lane_q[4];
   assign out5        = lane_q[5];
   assign out6        = lane_q[6];
   assign out7        = lane_q[7];
   assign out_strobe  = strobe_q;
   assign out_sel     = sel_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_tdm_demux_8.sv
// tb_tdm_demux_8 -- scoreboard bench for tdm_demux_8.
//
// Each driven cycle updates a behavioural frame model and pushes the
// expected strobe/sel/pulse/drop values; the scenario task pops and
// compares them one cycle later. Lane contents are checked against the
// model and against fixed per-scenario values.
module tb_tdm_demux_8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] in_data;
   logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
   logic [7:0] out_strobe;
   logic [2:0] out_sel;
   logic       frame_valid;
   logic       frame_err;
   logic [7:0] drop_cnt;

   tdm_demux_8 #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .in_data(in_data),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .out4(out4), .out5(out5), .out6(out6), .out7(out7),
      .out_strobe(out_strobe), .out_sel(out_sel),
      .frame_valid(frame_valid), .frame_err(frame_err),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] strobe;
      logic [2:0] sel;
      logic       fv;
      logic       fe;
      logic [7:0] drop;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   // Reference model state.
   logic       m_run;
   logic [2:0] m_slot;
   logic [2:0] m_sel;
   logic [7:0] m_drop;
   logic [7:0] m_lane [8];

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   function automatic logic [7:0] dut_lane(input int n);
      case (n)
         0: return out0;
         1: return out1;
         2: return out2;
         3: return out3;
         4: return out4;
         5: return out5;
         6: return out6;
         default: return out7;
      endcase
   endfunction

   // Drive one cycle, update the model, push the expectation, then wait
   // until #1 after the sampling edge.
   task automatic drive(input logic r, input logic v, input logic s,
                        input logic [7:0] d);
      exp_t x;
      rst = r; in_valid = v; in_sof = s; in_data = d;
      x.strobe = 8'd0; x.fv = 1'b0; x.fe = 1'b0;
      if (r) begin
         m_run = 1'b0; m_slot = 3'd0; m_sel = 3'd0; m_drop = 8'd0;
         for (int i = 0; i < 8; i++) m_lane[i] = 8'd0;
      end else if (v) begin
         if (s) begin
            x.fe = m_run;
            m_lane[0] = d; x.strobe = 8'h01; m_sel = 3'd0;
            m_slot = 3'd1; m_run = 1'b1;
         end else if (!m_run) begin
            if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
         end else begin
            m_lane[m_slot] = d;
            x.strobe = 8'd1 << m_slot;
            m_sel = m_slot;
            if (m_slot == 3'd7) begin
               x.fv = 1'b1; m_slot = 3'd0; m_run = 1'b0;
            end else begin
               m_slot = m_slot + 3'd1;
            end
         end
      end
      x.sel = m_sel; x.drop = m_drop;
      sb.push_back(x);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b1, 1'b1, 8'h55);
      drive(1'b1, 1'b1, 1'b0, 8'h66);
      sb.delete();
      n_chk++;
      if ({out_strobe, out_sel, frame_valid, frame_err, drop_cnt} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got st=%h sel=%0d fv=%b fe=%b drop=%0d, want all zero",
                  out_strobe, out_sel, frame_valid, frame_err, drop_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (dut_lane(i) !== 8'h00) begin
            n_err++;
            $display("FAIL reset_lane%0d: got %h want 00", i, dut_lane(i));
         end
      end
   endtask

   task automatic test_full_frame;
      int fv_seen = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, (i == 0), 8'h80 >> i);
         e = sb.pop_front();
         n_chk++;
         if ({out_strobe, out_sel, frame_valid, frame_err, drop_cnt} !==
             {e.strobe, e.sel, e.fv, e.fe, e.drop}) begin
            n_err++;
            $display("FAIL full_frame w%0d: got st=%h sel=%0d fv=%b fe=%b drop=%0d want st=%h sel=%0d fv=%b fe=%b drop=%0d",
                     i, out_strobe, out_sel, frame_valid, frame_err, drop_cnt,
                     e.strobe, e.sel, e.fv, e.fe, e.drop);
         end
         if (frame_valid) fv_seen++;
      end
      n_chk++;
      if (fv_seen != 1 || out_strobe !== 8'h80) begin
         n_err++;
         $display("FAIL full_frame_fv: got %0d pulses (last st=%h) want 1 with st=80",
                  fv_seen, out_strobe);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (dut_lane(i) !== (8'h80 >> i)) begin
            n_err++;
            $display("FAIL full_frame_lane%0d: got %h want %h", i, dut_lane(i), 8'h80 >> i);
         end
      end
   endtask

   task automatic test_gapped_frame;
      int fv_cyc = -1;
      int w = 0;
      for (int i = 0; i < 11; i++) begin
         if (i >= 4 && i < 7) drive(1'b0, 1'b0, 1'b0, 8'hEE);
         else begin
            drive(1'b0, 1'b1, (w == 0), 8'h80 >> w);
            w++;
         end
         e = sb.pop_front();
         n_chk++;
         if ({out_strobe, out_sel, frame_valid, frame_err, drop_cnt} !==
             {e.strobe, e.sel, e.fv, e.fe, e.drop}) begin
            n_err++;
            $display("FAIL gapped c%0d: got st=%h sel=%0d fv=%b fe=%b drop=%0d want st=%h sel=%0d fv=%b fe=%b drop=%0d",
                     i, out_strobe, out_sel, frame_valid, frame_err, drop_cnt,
                     e.strobe, e.sel, e.fv, e.fe, e.drop);
         end
         if (frame_valid) fv_cyc = i;
      end
      n_chk++;
      if (fv_cyc != 10) begin
         n_err++;
         $display("FAIL gapped_fv: got pulse at cycle %0d want 10", fv_cyc);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (dut_lane(i) !== (8'h80 >> i)) begin
            n_err++;
            $display("FAIL gapped_lane%0d: got %h want %h", i, dut_lane(i), 8'h80 >> i);
         end
      end
   endtask

   task automatic test_mid_sof;
      logic [7:0] data [5] = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'hDD};
      logic       sof  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, sof[i], data[i]);
         e = sb.pop_front();
         n_chk++;
         if ({out_strobe, out_sel, frame_valid, frame_err, drop_cnt} !==
             {e.strobe, e.sel, e.fv, e.fe, e.drop}) begin
            n_err++;
            $display("FAIL mid_sof w%0d: got st=%h sel=%0d fv=%b fe=%b drop=%0d want st=%h sel=%0d fv=%b fe=%b drop=%0d",
                     i, out_strobe, out_sel, frame_valid, frame_err, drop_cnt,
                     e.strobe, e.sel, e.fv, e.fe, e.drop);
         end
         if (i == 3) begin
            n_chk++;
            if (frame_err !== 1'b1 || out0 !== 8'h11 || out1 !== 8'hBB) begin
               n_err++;
               $display("FAIL mid_sof_err: got fe=%b out0=%h out1=%h want fe=1 out0=11 out1=BB",
                        frame_err, out0, out1);
            end
         end
      end
      n_chk++;
      if (out1 !== 8'hDD || out2 !== 8'hCC) begin
         n_err++;
         $display("FAIL mid_sof_next: got out1=%h out2=%h want out1=DD out2=CC", out1, out2);
      end
      // Finish the restarted frame (slots 2..7) so the block returns to IDLE.
      for (int i = 2; i < 8; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h20 + 8'(i));
         e = sb.pop_front();
         n_chk++;
         if ({out_strobe, out_sel, frame_valid, frame_err, drop_cnt} !==
             {e.strobe, e.sel, e.fv, e.fe, e.drop}) begin
            n_err++;
            $display("FAIL mid_sof_tail s%0d: got st=%h fv=%b fe=%b want st=%h fv=%b fe=%b",
                     i, out_strobe, frame_valid, frame_err, e.strobe, e.fv, e.fe);
         end
      end
   endtask

   task automatic test_idle_drop;
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
         e = sb.pop_front();
         n_chk++;
         if ({out_strobe, out_sel, frame_valid, frame_err, drop_cnt} !==
             {e.strobe, e.sel, e.fv, e.fe, e.drop}) begin
            n_err++;
            if (bad++ < 5)
               $display("FAIL idle_drop w%0d: got st=%h drop=%0d want st=%h drop=%0d",
                        i, out_strobe, drop_cnt, e.strobe, e.drop);
         end
      end
      n_chk++;
      if (drop_cnt !== 8'd255) begin
         n_err++;
         $display("FAIL idle_drop_sat: got %0d want 255", drop_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (dut_lane(i) !== m_lane[i]) begin
            n_err++;
            $display("FAIL idle_drop_lane%0d: got %h want %h", i, dut_lane(i), m_lane[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      drive(1'b0, 1'b1, 1'b1, 8'h01);
      drive(1'b0, 1'b1, 1'b0, 8'h02);
      drive(1'b0, 1'b1, 1'b0, 8'h03);
      drive(1'b1, 1'b1, 1'b0, 8'h44);
      drive(1'b0, 1'b1, 1'b0, 8'h55);
      for (int i = 0; i < 5; i++) begin
         e = sb.pop_front();
         if (i == 3) begin
            n_chk++;
            if ({e.strobe, e.fv, e.fe, e.drop} !== 18'd0) begin
               n_err++;
               $display("FAIL reset_mid_model: model not cleared");
            end
         end
      end
      n_chk++;
      if ({out_strobe, frame_valid, frame_err} !== 10'd0 || drop_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL reset_mid_drop: got st=%h fv=%b fe=%b drop=%0d want st=00 fv=0 fe=0 drop=1",
                  out_strobe, frame_valid, frame_err, drop_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (dut_lane(i) !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_lane%0d: got %h want 00", i, dut_lane(i));
         end
      end
   endtask

   task automatic test_back_to_back;
      int fv_at [$];
      int fe_seen = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, (i % 8 == 0), 8'h10 + 8'(i));
         e = sb.pop_front();
         n_chk++;
         if ({out_strobe, out_sel, frame_valid, frame_err, drop_cnt} !==
             {e.strobe, e.sel, e.fv, e.fe, e.drop}) begin
            n_err++;
            $display("FAIL b2b w%0d: got st=%h sel=%0d fv=%b fe=%b drop=%0d want st=%h sel=%0d fv=%b fe=%b drop=%0d",
                     i, out_strobe, out_sel, frame_valid, frame_err, drop_cnt,
                     e.strobe, e.sel, e.fv, e.fe, e.drop);
         end
         if (frame_valid) fv_at.push_back(cyc);
         if (frame_err) fe_seen++;
      end
      n_chk++;
      if (fv_at.size() != 2 || fe_seen != 0) begin
         n_err++;
         $display("FAIL b2b_pulses: got fv=%0d fe=%0d want fv=2 fe=0", fv_at.size(), fe_seen);
      end else begin
         n_chk++;
         if (fv_at[1] - fv_at[0] != 8) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles want 8", fv_at[1] - fv_at[0]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (dut_lane(i) !== 8'h18 + 8'(i)) begin
            n_err++;
            $display("FAIL b2b_lane%0d: got %h want %h", i, dut_lane(i), 8'h18 + 8'(i));
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'd0;
      m_run = 1'b0; m_slot = 3'd0; m_sel = 3'd0; m_drop = 8'd0;
      for (int i = 0; i < 8; i++) m_lane[i] = 8'd0;
      @(posedge clk);
      #1;
      test_reset;
      test_full_frame;
      test_gapped_frame;
      test_mid_sof;
      test_idle_drop;
      test_reset_mid_frame;
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      sb.delete();
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
